// File: rtl/mem_sp_ram_pkg.sv
// Shared sizing defaults and word/address types for the single-port RAM behind the MBR.
package mem_sp_ram_pkg;

    localparam int DATA_W_DEF = 8;
    localparam int ADDR_W_DEF = 4;
    localparam int DEPTH_DEF  = 16;

    typedef logic [DATA_W_DEF-1:0] word_t;
    typedef logic [ADDR_W_DEF-1:0] addr_t;

endpackage : mem_sp_ram_pkg

// File: rtl/mem_sp_ram_array.sv
// DEPTH x DATA_W register array with asynchronous clear, one write port and a combinational read mux.
module mem_sp_ram_array
    import mem_sp_ram_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DEPTH  = DEPTH_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];

    // Next-state of every word: only the addressed word takes wdata; out-of-range writes match nothing.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            if (we && (addr == ADDR_W'(i))) begin
                mem_d[i] = wdata;
            end else begin
                mem_d[i] = mem_q[i];
            end
        end
    end

    // Storage words, cleared asynchronously so contents read as zero the instant reset asserts.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= {DATA_W{1'b0}};
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
        end
    end

    // Read mux; addresses beyond DEPTH return zero.
    always_comb begin
        if ({1'b0, addr} < DEPTH_L) begin
            rdata = mem_q[addr];
        end else begin
            rdata = {DATA_W{1'b0}};
        end
    end

endmodule : mem_sp_ram_array

// File: rtl/mem_sp_ram.sv
// Single-port synchronous RAM with registered read data (douta) for the memory buffer register.
// Optional MEM_SP_RAM_WRITE_FIRST_EN: a write edge returns dina on douta instead of the old word.
module mem_sp_ram
    import mem_sp_ram_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DEPTH  = DEPTH_DEF
) (
    input  logic              clka,
    input  logic              rsta,
    input  logic              wea,
    input  logic [ADDR_W-1:0] addra,
    input  logic [DATA_W-1:0] dina,
    output logic [DATA_W-1:0] douta
);

    logic [DATA_W-1:0] rd_data_s;
    logic [DATA_W-1:0] douta_d;
    logic [DATA_W-1:0] douta_q;

    mem_sp_ram_array #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_array (
        .clk   (clka),
        .rst   (rsta),
        .we    (wea),
        .addr  (addra),
        .wdata (dina),
        .rdata (rd_data_s)
    );

    // Read-data select: rd_data_s still holds the pre-write word, which gives read-first by default.
    always_comb begin
`ifdef MEM_SP_RAM_WRITE_FIRST_EN
        if (wea) begin
            douta_d = dina;
        end else begin
            douta_d = rd_data_s;
        end
`else
        douta_d = rd_data_s;
`endif
    end

    // Output register; updates on every edge out of reset, no read enable.
    always_ff @(posedge clka or posedge rsta) begin
        if (rsta) begin
            douta_q <= {DATA_W{1'b0}};
        end else begin
            douta_q <= douta_d;
        end
    end

    assign douta = douta_q;

endmodule : mem_sp_ram

// File: tb/tb_mem_sp_ram.sv
// Table-driven self-checking bench for mem_sp_ram, with hand-written reset sequences.
module tb_mem_sp_ram;
    import mem_sp_ram_pkg::*;

    logic  clka;
    logic  rsta;
    logic  wea;
    addr_t addra;
    word_t dina;
    word_t douta;

    int n_tests;
    int n_fail;

    typedef struct {
        logic  we;
        addr_t addr;
        word_t din;
        logic  chk;
        word_t exp;
        string name;
    } vec_t;

    vec_t vecs[$];

    mem_sp_ram dut (
        .clka  (clka),
        .rsta  (rsta),
        .wea   (wea),
        .addra (addra),
        .dina  (dina),
        .douta (douta)
    );

    initial clka = 1'b0;
    always #5 clka = ~clka;

    task automatic check(input string name, input word_t act, input word_t exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: douta=%h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic add(input logic we, input addr_t a, input word_t d,
                       input logic chk, input word_t exp, input string name);
        vec_t v;
        v.we = we; v.addr = a; v.din = d; v.chk = chk; v.exp = exp; v.name = name;
        vecs.push_back(v);
    endtask

    // One clock: drive on the falling edge, sample 1 time unit after the rising edge.
    task automatic step(input logic we, input addr_t a, input word_t d);
        @(negedge clka);
        wea = we; addra = a; dina = d;
        @(posedge clka);
        #1;
    endtask

    word_t rdw_exp;

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rsta = 1'b1; wea = 1'b0; addra = 4'h0; dina = 8'h00;

`ifdef MEM_SP_RAM_WRITE_FIRST_EN
        rdw_exp = 8'h22;
`else
        rdw_exp = 8'h11;
`endif

        // T2 write/read
        add(1'b1, 4'h3, 8'hAA, 1'b0, 8'h00, "t2_wr");
        add(1'b0, 4'h3, 8'h00, 1'b1, 8'hAA, "t2_rd3");
        add(1'b0, 4'h2, 8'h00, 1'b1, 8'h00, "t2_rd2");
        // T3 fill and sequential read-back
        for (int i = 0; i < 16; i++) add(1'b1, addr_t'(i), 8'hF0 ^ 8'(i), 1'b0, 8'h00, "t3_wr");
        for (int i = 0; i < 16; i++) add(1'b0, addr_t'(i), 8'h00, 1'b1, 8'hF0 ^ 8'(i), "t3_rd");
        add(1'b0, 4'h0, 8'h00, 1'b1, 8'hF0, "t3_rd0_again");
        // T4 read-during-write
        add(1'b1, 4'h5, 8'h11, 1'b0, 8'h00, "t4_pre");
        add(1'b1, 4'h5, 8'h22, 1'b1, rdw_exp, "t4_rdw");
        add(1'b0, 4'h5, 8'h00, 1'b1, 8'h22, "t4_after");
        // T5 back-to-back writes
        add(1'b1, 4'h7, 8'h01, 1'b0, 8'h00, "t5_w1");
        add(1'b1, 4'h7, 8'h02, 1'b0, 8'h00, "t5_w2");
        add(1'b1, 4'h8, 8'h33, 1'b0, 8'h00, "t5_w8");
        add(1'b0, 4'h7, 8'h00, 1'b1, 8'h02, "t5_rd7");
        add(1'b0, 4'h8, 8'h00, 1'b1, 8'h33, "t5_rd8");

        // Initial reset: edges during reset must leave douta at zero
        repeat (3) @(posedge clka);
        #1;
        check("rst_init", douta, 8'h00);
        @(negedge clka);
        rsta = 1'b0;

        // T1: get 8'h5A onto douta, then assert reset mid-cycle
        step(1'b1, 4'h1, 8'h5A);
        step(1'b0, 4'h1, 8'h00);
        check("t1_pre", douta, 8'h5A);
        #2;
        rsta = 1'b1;
        #1;
        check("t1_async", douta, 8'h00);
        @(posedge clka);
        #1;
        check("t1_edge_in_rst", douta, 8'h00);
        @(negedge clka);
        rsta = 1'b0;
        for (int i = 0; i < 16; i++) begin
            step(1'b0, addr_t'(i), 8'h00);
            check("t1_clear", douta, 8'h00);
        end

        for (int k = 0; k < vecs.size(); k++) begin
            step(vecs[k].we, vecs[k].addr, vecs[k].din);
            if (vecs[k].chk) check(vecs[k].name, douta, vecs[k].exp);
        end

        // T6: pulse reset between edges while douta holds 8'h33
        step(1'b0, 4'h8, 8'h00);
        check("t6_pre", douta, 8'h33);
        #2;
        rsta = 1'b1;
        #1;
        check("t6_async", douta, 8'h00);
        #1;
        rsta = 1'b0;
        #1;
        check("t6_held", douta, 8'h00);
        step(1'b0, 4'h8, 8'h00);
        check("t6_rd8", douta, 8'h00);
        step(1'b0, 4'h7, 8'h00);
        check("t6_rd7", douta, 8'h00);
        step(1'b0, 4'h5, 8'h00);
        check("t6_rd5", douta, 8'h00);
        step(1'b0, 4'h3, 8'h00);
        check("t6_rd3", douta, 8'h00);

        // First edge after release operates normally
        step(1'b1, 4'hF, 8'hC3);
        step(1'b0, 4'hF, 8'h00);
        check("t6_post_wr", douta, 8'hC3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_mem_sp_ram
